// File: rtl/rv64_divider.sv
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU.
// Define RV64_DIV_WORD_EN to add the 32-bit W variants (DIVW, DIVUW, REMW, REMUW).
module rv64_divider #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         flush,
  input  logic         word,
  input  logic [1:0]   divOp,
  input  logic [N-1:0] dataA,
  input  logic [N-1:0] dataB,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

  state_e          state_q, state_d;
  logic            busy_q, busy_d, done_q, done_d;
  logic [N-1:0]    result_q, res_q;
  logic [N-1:0]    quo_q, rem_q, div_q;
  logic [CntW-1:0] cnt_q, cnt_init;
  logic            rem_sel_q, q_neg_q, r_neg_q;

  logic            sgn, a_neg, b_neg, div_zero, ovf, special, accept, idle_sel;
  logic [N-1:0]    a_ext, b_ext, min_val, a_abs, b_abs, quo_init;
  logic [N-1:0]    q_fin, r_fin, res_pick;
  logic [N:0]      shifted, diff;
  logic            borrow;

  assign sgn = ~divOp[0];

`ifdef RV64_DIV_WORD_EN
  logic word_q;

  always_comb begin
    a_ext    = dataA;
    b_ext    = dataB;
    min_val  = {1'b1, {(N-1){1'b0}}};
    cnt_init = CntW'(N);
    if (word) begin
      a_ext    = {{(N-32){sgn & dataA[31]}}, dataA[31:0]};
      b_ext    = {{(N-32){sgn & dataB[31]}}, dataB[31:0]};
      min_val  = {{(N-31){1'b1}}, {31{1'b0}}};
      cnt_init = CntW'(32);
    end
  end

  // W dividends start in the upper half so the MSB-first shift is width-independent.
  assign quo_init = word ? (a_abs << 32) : a_abs;
`else
  logic unused_word;

  assign unused_word = word;
  assign a_ext       = dataA;
  assign b_ext       = dataB;
  assign min_val     = {1'b1, {(N-1){1'b0}}};
  assign cnt_init    = CntW'(N);
  assign quo_init    = a_abs;
`endif

  assign a_neg    = sgn & a_ext[N-1];
  assign b_neg    = sgn & b_ext[N-1];
  assign a_abs    = a_neg ? -a_ext : a_ext;
  assign b_abs    = b_neg ? -b_ext : b_ext;
  assign div_zero = (b_ext == '0);
  assign ovf      = sgn && (a_ext == min_val) && (b_ext == '1);
  assign special  = div_zero | ovf;
  assign accept   = (state_q == StIdle) && !busy_q && start && !flush;

  // Partial remainder never exceeds twice the divisor, so a set top bit means no borrow.
  assign shifted = {rem_q, quo_q[N-1]};
  assign diff    = shifted - {1'b0, div_q};
  assign borrow  = ~shifted[N] & diff[N];

  // In IDLE this resolves a special case; in FIX it sign-corrects the iterated result.
  always_comb begin
    idle_sel = (state_q == StIdle);
    q_fin    = idle_sel ? (div_zero ? '1 : a_ext) : (q_neg_q ? -quo_q : quo_q);
    r_fin    = idle_sel ? (div_zero ? a_ext : '0) : (r_neg_q ? -rem_q : rem_q);
    res_pick = (idle_sel ? divOp[1] : rem_sel_q) ? r_fin : q_fin;
`ifdef RV64_DIV_WORD_EN
    if (idle_sel ? word : word_q) begin
      res_pick = {{(N-32){res_pick[31]}}, res_pick[31:0]};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (accept) state_d = special ? StDone : StCalc;
      StCalc: if (cnt_q == CntW'(1)) state_d = StFix;
      StFix:  state_d = StDone;
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush && (state_q != StIdle)) begin
      state_d = StIdle;
    end
  end

  // busy stays up for the cycle after done so a new start only lands once busy reads low.
  always_comb begin
    busy_d = (state_d != StIdle) || ((state_q == StDone) && !flush);
    done_d = (state_q == StDone) && !flush;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      res_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      rem_sel_q <= 1'b0;
      q_neg_q   <= 1'b0;
      r_neg_q   <= 1'b0;
`ifdef RV64_DIV_WORD_EN
      word_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            rem_sel_q <= divOp[1];
`ifdef RV64_DIV_WORD_EN
            word_q    <= word;
`endif
            div_q     <= b_abs;
            rem_q     <= '0;
            quo_q     <= quo_init;
            cnt_q     <= cnt_init;
            q_neg_q   <= a_neg ^ b_neg;
            r_neg_q   <= a_neg;
            if (special) begin
              res_q <= res_pick;
            end
          end
        end
        StCalc: begin
          rem_q <= borrow ? shifted[N-1:0] : diff[N-1:0];
          quo_q <= {quo_q[N-2:0], ~borrow};
          cnt_q <= cnt_q - CntW'(1);
        end
        StFix: res_q <= res_pick;
        StDone: if (!flush) result_q <= res_q;
        default: ;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_rv64_divider.sv
// Self-checking bench for rv64_divider: directed RISC-V M cases, control corner cases and
// randomized operations against an arithmetic reference model.
module tb_rv64_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        word = 1'b0;
  logic [1:0]  divOp = 2'b00;
  logic [63:0] dataA = '0;
  logic [63:0] dataB = '0;
  logic        busy, done;
  logic [63:0] result;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] last_res = '0;

  rv64_divider #(.N(64)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .flush  (flush),
    .word   (word),
    .divOp  (divOp),
    .dataA  (dataA),
    .dataB  (dataB),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic w_eff(input logic w);
`ifdef RV64_DIV_WORD_EN
    return w;
`else
    return w & 1'b0;
`endif
  endfunction

  // RISC-V M semantics computed with native signed/unsigned division.
  function automatic void ref_model(input logic [1:0] op, input logic w, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] res,
                                    output logic special);
    logic        sgn;
    logic [31:0] r32;
    int          sa32, sb32;
    longint      sa, sb;
    sgn     = !op[0];
    special = 1'b0;
    if (w) begin
      sa32 = a[31:0];
      sb32 = b[31:0];
      if (b[31:0] == 32'h0) begin
        special = 1'b1;
        r32 = op[1] ? a[31:0] : 32'hFFFF_FFFF;
      end else if (sgn && a[31:0] == 32'h8000_0000 && b[31:0] == 32'hFFFF_FFFF) begin
        special = 1'b1;
        r32 = op[1] ? 32'h0 : a[31:0];
      end else if (sgn) begin
        r32 = op[1] ? 32'(sa32 % sb32) : 32'(sa32 / sb32);
      end else begin
        r32 = op[1] ? a[31:0] % b[31:0] : a[31:0] / b[31:0];
      end
      res = {{32{r32[31]}}, r32};
    end else begin
      sa = a;
      sb = b;
      if (b == 64'h0) begin
        special = 1'b1;
        res = op[1] ? a : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (sgn && a == 64'h8000_0000_0000_0000 && b == 64'hFFFF_FFFF_FFFF_FFFF) begin
        special = 1'b1;
        res = op[1] ? 64'h0 : a;
      end else if (sgn) begin
        res = op[1] ? 64'(sa % sb) : 64'(sa / sb);
      end else begin
        res = op[1] ? a % b : a / b;
      end
    end
  endfunction

  // poke_at: re-pulse start that many cycles in; flush_at: flush instead of completing.
  task automatic run_op(input string tag, input logic [1:0] op, input logic w,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                        input int exp_lat, input int poke_at, input int flush_at);
    int lat;
    int guard;
    int dones;
    guard = 0;
    while (busy && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_idle"}, {63'h0, busy}, 64'h0);
    divOp = op;
    word  = w;
    dataA = a;
    dataB = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check_eq({tag, "_busy"}, {63'h0, busy}, 64'h1);
    lat   = 0;
    dones = 0;
    if (flush_at == 0) begin
      while (!done && lat < 200) begin
        @(negedge clk);
        lat++;
        if (lat == poke_at) begin
          start = 1'b1;
          divOp = 2'b01;
          dataA = {$urandom, $urandom};
          dataB = 64'h3;
        end else begin
          start = 1'b0;
        end
      end
      start = 1'b0;
      check_eq({tag, "_done"}, {63'h0, done}, 64'h1);
      check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
      check_eq({tag, "_res"}, result, exp);
      last_res = exp;
      @(negedge clk);
      check_eq({tag, "_pulse"}, {63'h0, done}, 64'h0);
    end else begin
      while (lat < flush_at) begin
        @(negedge clk);
        lat++;
        dones += int'(done);
      end
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_eq({tag, "_fl_busy"}, {63'h0, busy}, 64'h0);
      check_eq({tag, "_fl_res"}, result, last_res);
      repeat (80) begin
        @(negedge clk);
        dones += int'(done);
      end
      check_eq({tag, "_fl_nodone"}, 64'(dones), 64'h0);
    end
  endtask

  initial begin
    logic [63:0] exp;
    logic        spc;
    logic [1:0]  op;
    logic        w;
    logic [63:0] a, b;
    int          sel;

    #12;
    check_eq("rst_busy", {63'h0, busy}, 64'h0);
    check_eq("rst_done", {63'h0, done}, 64'h0);
    check_eq("rst_result", result, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("div_neg", 2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66, 0, 0);
    run_op("rem_neg", 2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFEC, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66, 0, 0);
    run_op("divu_max", 2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 66, 0, 0);
    run_op("remu_max", 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h1, 66, 0, 0);
    run_op("div_zero", 2'b00, 1'b0, 64'd123, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1, 0, 0);
    run_op("rem_zero", 2'b10, 1'b0, 64'd123, 64'd0, 64'd123, 1, 0, 0);
    run_op("div_ovf", 2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1, 0, 0);
    run_op("rem_ovf", 2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1, 0, 0);
`ifdef RV64_DIV_WORD_EN
    run_op("divw_ovf", 2'b00, 1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_8000_0000, 1, 0, 0);
    run_op("divuw", 2'b01, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, 34, 0, 0);
`else
    run_op("divw_ovf", 2'b00, 1'b1, 64'h1234_5678_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hEDCB_A987_8000_0000, 66, 0, 0);
    run_op("divuw", 2'b01, 1'b1, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'h0000_0000_FFFF_FFFE, 66, 0, 0);
`endif
    run_op("busy_start", 2'b00, 1'b0, 64'd1000, 64'd7, 64'd142, 66, 10, 0);
    run_op("flush", 2'b00, 1'b0, 64'd5000, 64'd9, 64'd0, 0, 0, 20);

    for (int i = 0; i < 40; i++) begin
      op  = 2'($urandom_range(0, 3));
      w   = 1'($urandom_range(0, 1));
      a   = {$urandom, $urandom};
      b   = {$urandom, $urandom};
      sel = $urandom_range(0, 9);
      if (sel == 0) begin
        b = w ? {$urandom, 32'h0} : 64'h0;
      end else if (sel == 1) begin
        a = w ? {$urandom, 32'h8000_0000} : 64'h8000_0000_0000_0000;
        b = w ? {$urandom, 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
      end else if (sel == 2) begin
        b = 64'($urandom_range(1, 15));
      end else if (sel == 3) begin
        a = 64'($urandom_range(0, 1000));
      end
      ref_model(op, w_eff(w), a, b, exp, spc);
      run_op($sformatf("rnd%0d", i), op, w, a, b, exp, spc ? 1 : (w_eff(w) ? 34 : 66), 0, 0);
    end

    // Asynchronous reset in the middle of an operation.
    @(negedge clk);
    divOp = 2'b00;
    word  = 1'b0;
    dataA = 64'd77777;
    dataB = 64'd13;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (29) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", {63'h0, busy}, 64'h0);
    check_eq("midrst_done", {63'h0, done}, 64'h0);
    check_eq("midrst_result", result, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst", 2'b00, 1'b0, 64'd100, 64'd7, 64'd14, 66, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
